// File: rtl/score_keeper_pkg.sv
// rtl/score_keeper_pkg.sv - shared game state encoding and score limits
package score_keeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } game_state_t;

  localparam int SCORE_W           = 10;
  localparam int MAX_SCORE_DEFAULT = 999;

  // Three BCD digits cannot show more than 999, so larger ceilings are pulled down.
  function automatic logic [SCORE_W-1:0] clamp_max(input int m);
    return (m > 999) ? 10'd999 : SCORE_W'(m);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD counter digit with increment, clear and carry-out
module bcd_digit (
  input  logic       clk,
  input  logic       clr,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  assign carry = inc && (digit == 4'd9);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      digit <= 4'd0;
    end else if (clear) begin
      digit <= 4'd0;
    end else if (inc) begin
      digit <= carry ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - round FSM, saturating binary/BCD score and best-score tracking
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int MAX_SCORE = MAX_SCORE_DEFAULT
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        game_start,
  input  logic        game_over,
  input  logic        pipe_pass,
  output logic [9:0]  score,
  output logic [11:0] score_bcd,
  output logic [9:0]  best,
  output logic        new_best,
  output logic        inc_pulse,
  output logic [1:0]  state
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = clamp_max(MAX_SCORE);

  game_state_t        cur;
  logic               pipe_q;
  logic               start;
  logic               finish;
  logic               accept;
  logic [SCORE_W-1:0] score_next;
  logic               units_carry;
  logic               tens_carry;
  logic               unused_carry;

  assign start      = game_start && (cur != ST_PLAY);
  assign finish     = game_over && (cur == ST_PLAY);
  assign accept     = (cur == ST_PLAY) && pipe_pass && !pipe_q && (score != SCORE_MAX);
  // The best comparison sees this value, so a pass on the game_over cycle still counts.
  assign score_next = accept ? score + 10'd1 : score;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cur       <= ST_IDLE;
      pipe_q    <= 1'b0;
      score     <= '0;
      best      <= '0;
      new_best  <= 1'b0;
      inc_pulse <= 1'b0;
    end else begin
      pipe_q    <= pipe_pass;
      inc_pulse <= accept;
      if (start) begin
        cur      <= ST_PLAY;
        score    <= '0;
        new_best <= 1'b0;
      end else begin
        score <= score_next;
        if (finish) begin
          cur <= ST_OVER;
          if (score_next > best) begin
            best     <= score_next;
            new_best <= 1'b1;
          end
        end
      end
    end
  end

  bcd_digit u_units (
    .clk   (clk),
    .clr   (clr),
    .clear (start),
    .inc   (accept),
    .digit (score_bcd[3:0]),
    .carry (units_carry)
  );

  bcd_digit u_tens (
    .clk   (clk),
    .clr   (clr),
    .clear (start),
    .inc   (units_carry),
    .digit (score_bcd[7:4]),
    .carry (tens_carry)
  );

  // Saturation stops the chain at 999, so the hundreds carry never fires.
  bcd_digit u_hundreds (
    .clk   (clk),
    .clr   (clr),
    .clear (start),
    .inc   (tens_carry),
    .digit (score_bcd[11:8]),
    .carry (unused_carry)
  );

  assign state = cur;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - scoreboard bench for score_keeper
module tb_score_keeper;

  localparam int MAX = 999;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        game_start = 1'b0;
  logic        game_over = 1'b0;
  logic        pipe_pass = 1'b0;
  logic [9:0]  score;
  logic [11:0] score_bcd;
  logic [9:0]  best;
  logic        new_best;
  logic        inc_pulse;
  logic [1:0]  state;

  score_keeper #(.MAX_SCORE(MAX)) dut (
    .clk        (clk),
    .clr        (clr),
    .game_start (game_start),
    .game_over  (game_over),
    .pipe_pass  (pipe_pass),
    .score      (score),
    .score_bcd  (score_bcd),
    .best       (best),
    .new_best   (new_best),
    .inc_pulse  (inc_pulse),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int score;
    int bcd;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   m_state = 0;
  int   m_score = 0;
  int   m_best = 0;
  int   m_nb = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int to_bcd(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  // Every inc_pulse must match the oldest pending expected increment.
  always @(negedge clk) begin
    if (clr && inc_pulse) begin
      pulses++;
      if (q.size() == 0) begin
        check_eq("spurious_inc_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check_eq("sb_score", 32'(score), 32'(e.score));
        check_eq("sb_bcd", 32'(score_bcd), 32'(e.bcd));
        check_eq("sb_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 clr = 1'b0;
    m_state = 0; m_score = 0; m_best = 0; m_nb = 0;
    #1;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_score", 32'(score), 32'd0);
    check_eq("rst_bcd", 32'(score_bcd), 32'd0);
    check_eq("rst_best", 32'(best), 32'd0);
    check_eq("rst_new_best", 32'(new_best), 32'd0);
    check_eq("rst_inc_pulse", 32'(inc_pulse), 32'd0);
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic do_start();
    @(negedge clk);
    game_start = 1'b1;
    if (m_state != 1) begin
      m_state = 1; m_score = 0; m_nb = 0;
    end
    @(negedge clk);
    game_start = 1'b0;
  endtask

  task automatic do_over();
    @(negedge clk);
    game_over = 1'b1;
    if (m_state == 1) begin
      m_state = 2;
      if (m_score > m_best) begin
        m_best = m_score; m_nb = 1;
      end
    end
    @(negedge clk);
    game_over = 1'b0;
  endtask

  task automatic do_pass(input int hi, input logic with_over);
    @(negedge clk);
    pipe_pass = 1'b1;
    game_over = with_over;
    if (m_state == 1 && m_score < MAX) begin
      m_score++;
      q.push_back('{m_score, to_bcd(m_score), cyc + 1});
    end
    if (with_over && m_state == 1) begin
      m_state = 2;
      if (m_score > m_best) begin
        m_best = m_score; m_nb = 1;
      end
    end
    @(negedge clk);
    game_over = 1'b0;
    repeat (hi - 1) @(negedge clk);
    pipe_pass = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_state"}, 32'(state), 32'(m_state));
    check_eq({tag, "_score"}, 32'(score), 32'(m_score));
    check_eq({tag, "_bcd"}, 32'(score_bcd), 32'(to_bcd(m_score)));
    check_eq({tag, "_best"}, 32'(best), 32'(m_best));
    check_eq({tag, "_new_best"}, 32'(new_best), 32'(m_nb));
  endtask

  initial begin
    do_reset();

    // game_over while idle is ignored
    do_over();
    check_model("idle_over");

    do_start();
    pulses = 0;
    for (int i = 0; i < 5; i++) do_pass(3, 1'b0);
    @(negedge clk);
    check_model("five");
    check_eq("five_score_bcd", 32'(score_bcd), 32'h005);
    check_eq("five_pulses", 32'(pulses), 32'd5);

    // start inside PLAY is ignored
    do_start();
    for (int i = 0; i < 7; i++) do_pass(2, 1'b0);
    @(negedge clk);
    check_eq("twelve_bcd", 32'(score_bcd), 32'h012);
    check_model("twelve");

    do_over();
    check_model("over12");
    do_pass(2, 1'b0);
    @(negedge clk);
    check_model("over_pass_ignored");

    // mid-round asynchronous reset discards the round
    do_reset();
    do_start();
    for (int i = 0; i < 3; i++) do_pass(1, 1'b0);
    do_reset();

    do_start();
    for (int i = 0; i < 7; i++) do_pass(1, 1'b0);
    do_over();
    check_model("r1");
    check_eq("r1_best7", 32'(best), 32'd7);
    do_start();
    @(negedge clk);
    check_model("r2_start");
    for (int i = 0; i < 7; i++) do_pass(1, 1'b0);
    do_over();
    check_model("r2");
    do_start();
    for (int i = 0; i < 8; i++) do_pass(1, 1'b0);
    do_over();
    check_model("r3");
    check_eq("r3_best8", 32'(best), 32'd8);

    do_reset();
    do_start();
    for (int i = 0; i < 4; i++) do_pass(1, 1'b0);
    do_pass(1, 1'b1);
    @(negedge clk);
    check_model("coincide");
    check_eq("coincide_best5", 32'(best), 32'd5);

    // a level already high when PLAY starts is not counted
    @(negedge clk);
    pipe_pass = 1'b1;
    do_start();
    repeat (3) @(negedge clk);
    pipe_pass = 1'b0;
    check_model("level_on_entry");

    // run past saturation
    pulses = 0;
    for (int i = 0; i < 1001; i++) begin
      do_pass(1, 1'b0);
      if (i == 99) begin
        @(negedge clk);
        check_eq("hundred_bcd", 32'(score_bcd), 32'h100);
      end
    end
    @(negedge clk);
    check_model("sat");
    check_eq("sat_bcd", 32'(score_bcd), 32'h999);
    check_eq("sat_pulses", 32'(pulses), 32'd999);
    check_eq("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter MAX_SCORE, default 999, saturation ceiling of the score; SHALL be at most 999 so it fits three BCD digits.
REQ-002 Port clk  in  1  single system clock; all state SHALL change on its rising edge only.
REQ-003 Port clr  in  1  asynchronous reset, active-low; one clock, and the reset is asynchronous and active-low.
REQ-004 Port game_start  in  1  level from control FSM, synchronous to clk; requests a new round.
REQ-005 Port game_over  in  1  level, synchronous; bird collision or ground hit.
REQ-006 Port pipe_pass  in  1  level, synchronous; high while the bird is between pipe edges; may stay high many cycles.
REQ-007 Port score  out  10  current score, binary, feeds the score display stage.
REQ-008 Port score_bcd  out  12  current score as hundreds[11:8], tens[7:4], units[3:0].
REQ-009 Port best  out  10  highest score since reset, binary.
REQ-010 Port new_best  out  1  high in OVER when the finished round set a new best.
REQ-011 Port inc_pulse  out  1  one-cycle strobe on every accepted score increment.
REQ-012 Port state  out  2  IDLE=0, PLAY=1, OVER=2; 3 unused.

Function
REQ-013 FSM SHALL have states IDLE, PLAY, OVER; transitions IDLE->PLAY on game_start, PLAY->OVER on game_over, OVER->PLAY on game_start; all other input combinations hold state.
REQ-014 game_start in PLAY SHALL be ignored; game_over in IDLE or OVER SHALL be ignored.
REQ-015 On IDLE->PLAY and OVER->PLAY, score and score_bcd SHALL clear to 0 and new_best SHALL clear, in the same cycle as the transition; best SHALL be retained.
REQ-016 An increment is accepted when state==PLAY and pipe_pass is high while its registered copy from the previous cycle is low (rising edge); one increment per edge regardless of pulse length.
REQ-017 score, score_bcd and inc_pulse SHALL update on the clock edge following the first cycle pipe_pass is sampled high (1-cycle latency).
REQ-018 score_bcd SHALL be maintained incrementally as a BCD counter (units 9->0 carries into tens, tens 9->0 carries into hundreds), never by division, and SHALL equal the binary score at all times.
REQ-019 At score==MAX_SCORE an edge SHALL leave score and score_bcd unchanged and SHALL NOT assert inc_pulse.
REQ-020 If game_over and an accepted pipe_pass edge coincide in PLAY, the increment SHALL be applied first and the best comparison SHALL use the incremented value.
REQ-021 On PLAY->OVER, if the final score > best, best SHALL load the final score and new_best SHALL assert on the same edge; an equal score SHALL NOT update best or assert new_best.
REQ-022 In OVER and IDLE score SHALL hold its value; pipe_pass edges SHALL have no effect.
REQ-023 The pipe_pass edge register SHALL update every cycle in all states, so a level already high on entry to PLAY is not counted.

Reset
REQ-024 While clr is low: state=IDLE, score=0, score_bcd=0, best=0, new_best=0, inc_pulse=0, edge register=0, asynchronously.
REQ-025 Reset asserted mid-round SHALL discard the round without updating best; reset release SHALL be synchronised externally.

Structure
REQ-026 State encoding and MAX_SCORE default SHALL live in the shared game package used by the control FSM and the display stage.
REQ-027 One sub-module bcd_digit (4-bit BCD counter with inc, clear, carry-out, 9->0 wrap) SHALL be instantiated three times in a carry chain.
REQ-028 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-029 Reset, game_start 1 cycle, five pipe_pass pulses of 3 cycles each -> score=5, score_bcd=0x005, five inc_pulse strobes, each 1 cycle after pulse rise.
REQ-030 Twelve passes -> score_bcd steps 0x009->0x010 on the 10th, score=12, score_bcd=0x012; 100th pass -> 0x100.
REQ-031 MAX_SCORE=999, drive 1001 passes -> score=999, score_bcd=0x999, exactly 999 inc_pulse strobes.
REQ-032 Round 1 score 7 then game_over -> best=7, new_best=1; game_start, round 2 score 7, game_over -> best=7, new_best=0; round 3 score 8 -> best=8, new_best=1.
REQ-033 Score 4, pipe_pass rise and game_over in the same cycle -> state=OVER, score=5, best=5; clr low mid-round at score 3 -> all outputs 0, state IDLE immediately.
